fma_result_buffer: RTL and testbench

Downstream companion of the 4-stage `fma` SIMD pipeline. The `fma` has fixed latency and no valid or stall signalling. This block tracks each issued operation through a latency-matched valid/tag chain and captures the `fma` results (4 lanes, flags, certainty) into a FIFO. It drains the FIFO to the consumer with a valid/ready handshake, and it throttles issue with a credit check so that no result is ever lost.

---
 rtl/fma_pkg.sv | 29 ++
 rtl/fma_result_fifo.sv | 56 +++++
 rtl/fma_result_buffer.sv | 109 ++++++++++
 tb/tb_fma_result_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared definitions for the fma pipeline and its downstream result buffer.
package fma_pkg;

  localparam int FMA_LAT   = 4;
  localparam int FMA_WIDTH = 64;
  localparam int FMA_TAG_W = 4;
  localparam int FLAG_W    = 20;
  localparam int UO_W      = 24;

  typedef enum logic [1:0] {
    MODE_FMA = 2'b11,
    MODE_MUL = 2'b10,
    MODE_ADD = 2'b01
  } fma_mode_e;

  // One captured result; bit layout matches the flat FIFO word in the buffer.
  typedef struct packed {
    logic [3:0][FMA_WIDTH-1:0] lanes;
    logic [FLAG_W-1:0]         flags;
    logic [UO_W-1:0]           uo;
    logic [FMA_TAG_W-1:0]      tag;
    logic [1:0]                mode;
  } fma_entry_t;

  function automatic int entry_width(input int width, input int tag_w);
    return 4 * width + FLAG_W + UO_W + tag_w + 2;
  endfunction

endpackage

// File: rtl/fma_result_fifo.sv
// Synchronous FIFO with occupancy count. Writes into a full FIFO and reads
// from an empty one are ignored; the storage array is not reset.
module fma_result_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Entry storage, written at the write pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fma_result_buffer.sv
// Result buffer behind the fixed-latency fma pipeline: tracks issued ops with
// a latency-matched valid/tag chain, captures their results into a FIFO and
// throttles issue so the FIFO can never overflow.
module fma_result_buffer
  import fma_pkg::*;
#(
  parameter int WIDTH = FMA_WIDTH,
  parameter int LAT   = FMA_LAT,
  parameter int DEPTH = 8,
  parameter int TAG_W = FMA_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic [1:0]               issue_mode,
  output logic                     issue_ready,
  input  logic [WIDTH-1:0]         res0,
  input  logic [WIDTH-1:0]         res1,
  input  logic [WIDTH-1:0]         res2,
  input  logic [WIDTH-1:0]         res3,
  input  logic [FLAG_W-1:0]        res_flags,
  input  logic [UO_W-1:0]          res_uo,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*WIDTH-1:0]       out_data,
  output logic [FLAG_W-1:0]        out_flags,
  output logic [UO_W-1:0]          out_uo,
  output logic [TAG_W-1:0]         out_tag,
  output logic [1:0]               out_mode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_drop
);

  localparam int EW = entry_width(WIDTH, TAG_W);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [LAT-1:0]   trk_v;
  logic [TAG_W-1:0] trk_tag  [LAT];
  logic [1:0]       trk_mode [LAT];
  logic [CW:0]      inflight;
  logic             issue_acc;
  logic             fifo_empty;
  logic             fifo_full;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;

  // Credit counts results already stored plus those still inside the fma;
  // a pop in the same cycle earns no credit until it has happened.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + {{CW{1'b0}}, trk_v[i]};
  end

  assign issue_ready = (({1'b0, count}) + inflight) < DEPTH_C;
  assign issue_acc   = issue_valid && issue_ready;

  // Valid chain; reset clears it so results of pre-reset issues are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_v <= '0;
    end else begin
      trk_v[0] <= issue_acc;
      for (int i = 1; i < LAT; i++) trk_v[i] <= trk_v[i-1];
    end
  end

  // Tag and mode ride alongside the valid bit; only meaningful where v is set.
  always_ff @(posedge clk) begin
    trk_tag[0]  <= issue_tag;
    trk_mode[0] <= issue_mode;
    for (int i = 1; i < LAT; i++) begin
      trk_tag[i]  <= trk_tag[i-1];
      trk_mode[i] <= trk_mode[i-1];
    end
  end

  assign wr_entry = {res3, res2, res1, res0, res_flags, res_uo,
                     trk_tag[LAT-1], trk_mode[LAT-1]};

  // Sticky error: a rejected issue, or an arrival that finds the FIFO full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_drop <= 1'b0;
    end else if ((issue_valid && !issue_ready) || (trk_v[LAT-1] && fifo_full)) begin
      err_drop <= 1'b1;
    end
  end

  fma_result_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (trk_v[LAT-1]),
    .wdata (wr_entry),
    .pop   (out_valid && out_ready),
    .rdata (rd_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

  assign out_valid = !fifo_empty;
  assign {out_data, out_flags, out_uo, out_tag, out_mode} = rd_entry;

endmodule

// File: tb/tb_fma_result_buffer.sv
// Randomized scoreboard bench for fma_result_buffer with a behavioural fma
// delay-line model and a queue-level occupancy/credit reference model.
module tb_fma_result_buffer;

  localparam int WIDTH = 64;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int RW    = 4 * WIDTH + 20 + 24;
  localparam int XW    = RW + TAG_W + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               issue_valid;
  logic [TAG_W-1:0]   issue_tag;
  logic [1:0]         issue_mode;
  logic               issue_ready;
  logic [WIDTH-1:0]   res0, res1, res2, res3;
  logic [19:0]        res_flags;
  logic [23:0]        res_uo;
  logic               out_valid;
  logic               out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [19:0]        out_flags;
  logic [23:0]        out_uo;
  logic [TAG_W-1:0]   out_tag;
  logic [1:0]         out_mode;
  logic [3:0]         count;
  logic               err_drop;

  // fma input bundle presented alongside each issue, and its delay line
  logic [4*WIDTH-1:0] fin_lanes;
  logic [19:0]        fin_flags;
  logic [23:0]        fin_uo;
  logic [RW-1:0]      fpipe [LAT];

  // reference model
  logic [XW-1:0] sb_q [$];
  int            fl_rem [$];
  int            m_cnt;
  bit            m_err;
  bit            force_l0;
  logic [63:0]   l0_val;

  int n_checks = 0;
  int n_errs   = 0;

  fma_result_buffer #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_mode  (issue_mode),
    .issue_ready (issue_ready),
    .res0        (res0),
    .res1        (res1),
    .res2        (res2),
    .res3        (res3),
    .res_flags   (res_flags),
    .res_uo      (res_uo),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flags   (out_flags),
    .out_uo      (out_uo),
    .out_tag     (out_tag),
    .out_mode    (out_mode),
    .count       (count),
    .err_drop    (err_drop)
  );

  always #5 clk = ~clk;

  // The fma itself: unaffected by the buffer's reset, fixed LAT-edge latency.
  always @(posedge clk) begin
    fpipe[0] <= {fin_lanes, fin_flags, fin_uo};
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign {res3, res2, res1, res0, res_flags, res_uo} = fpipe[LAT-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: on every handshake the head must equal the oldest accepted issue.
  initial begin
    logic [XW-1:0] exp_e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errs++;
          $display("FAIL unexpected_result: got tag %0d with nothing expected", out_tag);
        end else begin
          exp_e = sb_q.pop_front();
          if ({out_data, out_flags, out_uo, out_tag, out_mode} !== exp_e) begin
            n_errs++;
            $display("FAIL result: got tag %0d data 0x%0h expected tag %0d data 0x%0h",
                     out_tag, out_data, exp_e[TAG_W+1:2], exp_e[XW-1:XW-4*WIDTH]);
          end
        end
      end
    end
  end

  // One clock cycle: drive, check model state, then advance the model past the edge.
  task automatic step(input bit iv, input logic [TAG_W-1:0] tg, input logic [1:0] md,
                      input bit ordy);
    bit m_rdy;
    bit acc;
    @(negedge clk);
    issue_valid = iv;
    issue_tag   = tg;
    issue_mode  = md;
    out_ready   = ordy;
    for (int i = 0; i < 8; i++) fin_lanes[i*32 +: 32] = $urandom;
    if (force_l0) fin_lanes[63:0] = l0_val;
    fin_flags = 20'($urandom);
    fin_uo    = 24'($urandom);
    #1;
    m_rdy = (m_cnt + fl_rem.size()) < DEPTH;
    check("issue_ready", 64'(issue_ready), 64'(m_rdy));
    check("count", 64'(count), 64'(m_cnt));
    check("out_valid", 64'(out_valid), 64'(m_cnt > 0));
    check("err_drop", 64'(err_drop), 64'(m_err));
    acc = iv && m_rdy;
    if (acc) sb_q.push_back({fin_lanes, fin_flags, fin_uo, tg, md});
    @(posedge clk);
    if (ordy && m_cnt > 0) m_cnt--;
    for (int i = 0; i < fl_rem.size(); i++) fl_rem[i]--;
    while (fl_rem.size() > 0 && fl_rem[0] == 0) begin
      void'(fl_rem.pop_front());
      m_cnt++;
    end
    if (acc) fl_rem.push_back(LAT);
    if (iv && !m_rdy) m_err = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (m_cnt + fl_rem.size()) > 0; i++) step(0, '0, 2'b11, 1);
    check("drain_left", 64'(m_cnt + fl_rem.size()), 64'd0);
  endtask

  function automatic logic [1:0] rmode();
    return 2'($urandom_range(1, 3));
  endfunction

  initial begin
    int acc8;
    rst = 1'b0;
    issue_valid = 1'b0; issue_tag = '0; issue_mode = 2'b11; out_ready = 1'b0;
    fin_lanes = '0; fin_flags = '0; fin_uo = '0;
    m_cnt = 0; m_err = 1'b0; force_l0 = 1'b0; l0_val = 64'h3FF0000000000000;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_err_drop", 64'(err_drop), 64'd0);
    rst = 1'b1;

    // single issue: tag 3, mode 11, lane0 = 1.0
    force_l0 = 1'b1;
    step(1, 4'd3, 2'b11, 0);
    force_l0 = 1'b0;
    repeat (3) step(0, '0, 2'b11, 0);
    #2;
    check("single_early_valid", 64'(out_valid), 64'd0);
    step(0, '0, 2'b11, 0);
    #2;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_lane0", out_data[63:0], 64'h3FF0000000000000);
    check("single_tag", 64'(out_tag), 64'd3);
    check("single_count", 64'(count), 64'd1);
    drain();

    // back-to-back stream, consumer always ready
    for (int t = 0; t < 16; t++) step(1, 4'(t), rmode(), 1);
    drain();

    // stalled consumer: compliant issuer fills exactly DEPTH entries
    acc8 = 0;
    for (int t = 0; t < 12; t++) begin
      if ((m_cnt + fl_rem.size()) < DEPTH) begin
        step(1, 4'(acc8), rmode(), 0);
        acc8++;
      end else begin
        step(0, '0, 2'b11, 0);
      end
    end
    repeat (LAT) step(0, '0, 2'b11, 0);
    #2;
    check("full_count", 64'(count), 64'd8);
    check("full_issue_ready", 64'(issue_ready), 64'd0);
    check("full_err_drop", 64'(err_drop), 64'd0);
    // illegal issue while out of credit
    step(1, 4'd15, 2'b10, 0);
    repeat (LAT + 1) step(0, '0, 2'b11, 0);
    #2;
    check("reject_err_drop", 64'(err_drop), 64'd1);
    check("reject_count", 64'(count), 64'd8);
    drain();

    // refill, then steady state with push and pop on the same edges
    for (int t = 0; t < 12; t++) step((m_cnt + fl_rem.size()) < DEPTH, 4'($urandom), rmode(), 0);
    for (int t = 0; t < 40; t++) step((m_cnt + fl_rem.size()) < DEPTH, 4'($urandom), rmode(), 1);
    // random mix
    for (int t = 0; t < 150; t++)
      step(($urandom_range(0, 3) != 0) && ((m_cnt + fl_rem.size()) < DEPTH),
           4'($urandom), rmode(), $urandom_range(0, 2) != 0);
    drain();

    // reset while operations are in flight
    step(1, 4'd5, 2'b11, 0);
    step(1, 4'd6, 2'b10, 0);
    step(1, 4'd7, 2'b01, 0);
    step(0, '0, 2'b11, 0);
    step(0, '0, 2'b11, 0);
    @(negedge clk);
    issue_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_issue_ready", 64'(issue_ready), 64'd1);
    check("midrst_err_drop", 64'(err_drop), 64'd0);
    sb_q.delete();
    fl_rem.delete();
    m_cnt = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 2) step(0, '0, 2'b11, 0);
    step(1, 4'd9, 2'b10, 0);
    repeat (LAT) step(0, '0, 2'b11, 0);
    #2;
    check("postrst_count", 64'(count), 64'd1);
    check("postrst_tag", 64'(out_tag), 64'd9);
    drain();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs + 1);
    $fatal(1, "timeout");
  end

endmodule
